// File: rtl/irb_phase_scheduler_pkg.sv
// rtl/irb_phase_scheduler_pkg.sv - shared types and helpers for the IRB phase scheduler
package irb_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_START,
    ST_WAIT_BSY,
    ST_EXPAND,
    ST_DW,
    ST_PROJECT,
    ST_WAIT_OUT,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_LOAD,
    SEQ_GAP
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ZERO_CH = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  typedef enum logic {
    KIND_EXPAND  = 1'b0,
    KIND_PROJECT = 1'b1
  } fetch_kind_t;

  // Batches needed to cover ch channels with 2**log2_macs MACs per batch
  function automatic logic [10:0] ceil_batches(input logic [9:0] ch, input int unsigned log2_macs);
    logic [10:0] sum;
    sum = {1'b0, ch} + ((11'd1 << log2_macs) - 11'd1);
    return sum >> log2_macs;
  endfunction

endpackage

// File: rtl/irb_phase_scheduler_if.sv
// rtl/irb_phase_scheduler_if.sv - config, fetch, block-control and status signals of the scheduler
interface irb_phase_scheduler_if #(
  parameter int BATCH_W = 7
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [9:0]         cfg_input_channels;
  logic [9:0]         cfg_expand_channels;
  logic [9:0]         cfg_output_channels;
  logic               cfg_use_residual;
  logic               fetch_req;
  logic               fetch_kind;
  logic [BATCH_W-1:0] fetch_batch;
  logic               fetch_ack;
  logic               irb_start_block;
  logic               irb_load_expand_data;
  logic               irb_load_project_data;
  logic               irb_dw_window_valid;
  logic               irb_use_residual;
  logic               irb_busy;
  logic               irb_output_valid;
  logic               done;
  logic               error;
  logic [1:0]         error_code;

  modport master (
    input  cfg_valid, cfg_input_channels, cfg_expand_channels, cfg_output_channels,
           cfg_use_residual, fetch_ack, irb_busy, irb_output_valid,
    output cfg_ready, fetch_req, fetch_kind, fetch_batch, irb_start_block,
           irb_load_expand_data, irb_load_project_data, irb_dw_window_valid,
           irb_use_residual, done, error, error_code
  );

  modport slave (
    output cfg_valid, cfg_input_channels, cfg_expand_channels, cfg_output_channels,
           cfg_use_residual, fetch_ack, irb_busy, irb_output_valid,
    input  cfg_ready, fetch_req, fetch_kind, fetch_batch, irb_start_block,
           irb_load_expand_data, irb_load_project_data, irb_dw_window_valid,
           irb_use_residual, done, error, error_code
  );
endinterface

// File: rtl/irb_phase_scheduler_batch_sequencer.sv
// rtl/irb_phase_scheduler_batch_sequencer.sv - fetch/load/gap loop over N operand batches
module irb_batch_sequencer
  import irb_sched_pkg::*;
#(
  parameter int BATCH_W = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  fetch_kind_t        kind,
  input  logic [BATCH_W-1:0] num_batches,
  input  logic               fetch_ack,
  output logic               fetch_req,
  output logic               fetch_kind,
  output logic [BATCH_W-1:0] fetch_batch,
  output logic               load,
  output logic               last_gap
);
  seq_state_t         state_q, state_d;
  fetch_kind_t        kind_q;
  logic [BATCH_W-1:0] batch_q, num_q;
  logic               final_batch;

  assign final_batch = (batch_q == num_q - BATCH_W'(1));
  assign fetch_batch = fetch_req ? batch_q : '0;
  assign fetch_kind  = fetch_req && (kind_q == KIND_PROJECT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      kind_q  <= KIND_EXPAND;
      batch_q <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        kind_q  <= kind;
        num_q   <= num_batches;
        batch_q <= '0;
      end else if (state_q == SEQ_GAP) begin
        batch_q <= final_batch ? '0 : batch_q + BATCH_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    load      = 1'b0;
    last_gap  = 1'b0;
    case (state_q)
      SEQ_IDLE:  if (start) state_d = SEQ_FETCH;
      SEQ_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) state_d = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        load    = 1'b1;
        state_d = SEQ_GAP;
      end
      SEQ_GAP: begin
        // the gap cycle keeps consecutive load strobes apart
        last_gap = final_batch;
        state_d  = final_batch ? SEQ_IDLE : SEQ_FETCH;
      end
      default:   state_d = SEQ_IDLE;
    endcase
  end
endmodule

// File: rtl/irb_phase_scheduler.sv
// rtl/irb_phase_scheduler.sv - sequences expand, depthwise and project phases of one IRB run
module irb_phase_scheduler
  import irb_sched_pkg::*;
#(
  parameter int NUM_MACS       = 16,
  parameter int DW_CYCLES      = 9,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BATCH_W        = 7
) (
  input logic                   clock,
  input logic                   reset,
  irb_phase_scheduler_if.master bus
);
  localparam int LOG2_MACS = $clog2(NUM_MACS);
  localparam int DW_W      = $clog2(DW_CYCLES + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  err_code_t          code_q, code_d;
  fetch_kind_t        seq_kind;
  logic [BATCH_W-1:0] eb_q, pb_q, dw_batch_q, seq_num;
  logic [DW_W-1:0]    dw_cyc_q;
  logic [TO_W-1:0]    tmo_q;
  logic               zero_ch_q, ov_seen_q, use_res_q, error_q;
  logic               accept, err_set, seq_start, seq_load, seq_last, dw_last, tmo_hit;

  assign accept  = bus.cfg_valid && (state_q == ST_IDLE);
  assign tmo_hit = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));
  // DW spans PB * DW_CYCLES cycles: cycles within a batch, then batches
  assign dw_last = (dw_cyc_q == DW_W'(DW_CYCLES - 1)) && (dw_batch_q == pb_q - BATCH_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      code_q     <= ERR_NONE;
      error_q    <= 1'b0;
      eb_q       <= '0;
      pb_q       <= '0;
      zero_ch_q  <= 1'b0;
      use_res_q  <= 1'b0;
      ov_seen_q  <= 1'b0;
      tmo_q      <= '0;
      dw_cyc_q   <= '0;
      dw_batch_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        eb_q      <= BATCH_W'(ceil_batches(bus.cfg_input_channels, LOG2_MACS));
        pb_q      <= BATCH_W'(ceil_batches(bus.cfg_expand_channels, LOG2_MACS));
        zero_ch_q <= (bus.cfg_input_channels == '0) || (bus.cfg_expand_channels == '0) ||
                     (bus.cfg_output_channels == '0);
        use_res_q <= bus.cfg_use_residual;
        error_q   <= 1'b0;
        code_q    <= ERR_NONE;
      end else if (err_set) begin
        error_q <= 1'b1;
        code_q  <= code_d;
      end
      // an output_valid that arrives before WAIT_OUT must not be lost
      if (accept) ov_seen_q <= 1'b0;
      else if (state_q != ST_IDLE && bus.irb_output_valid) ov_seen_q <= 1'b1;
      if (state_d != state_q) tmo_q <= '0;
      else if (state_q == ST_WAIT_BSY || state_q == ST_WAIT_OUT) tmo_q <= tmo_q + TO_W'(1);
      if (state_q != ST_DW) begin
        dw_cyc_q   <= '0;
        dw_batch_q <= '0;
      end else if (dw_cyc_q == DW_W'(DW_CYCLES - 1)) begin
        dw_cyc_q   <= '0;
        dw_batch_q <= dw_batch_q + BATCH_W'(1);
      end else begin
        dw_cyc_q <= dw_cyc_q + DW_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = ERR_NONE;
    err_set   = 1'b0;
    seq_start = 1'b0;
    seq_kind  = KIND_EXPAND;
    seq_num   = eb_q;
    case (state_q)
      ST_IDLE:     if (bus.cfg_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        if (zero_ch_q) begin
          state_d = ST_ERR;
          err_set = 1'b1;
          code_d  = ERR_ZERO_CH;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START:    state_d = ST_WAIT_BSY;
      ST_WAIT_BSY: begin
        if (bus.irb_busy) begin
          state_d   = ST_EXPAND;
          seq_start = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
          err_set = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_EXPAND:   if (seq_last) state_d = ST_DW;
      ST_DW: begin
        if (dw_last) begin
          state_d   = ST_PROJECT;
          seq_start = 1'b1;
          seq_kind  = KIND_PROJECT;
          seq_num   = pb_q;
        end
      end
      ST_PROJECT:  if (seq_last) state_d = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (bus.irb_output_valid || ov_seen_q) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
          err_set = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  irb_batch_sequencer #(.BATCH_W(BATCH_W)) u_seq (
    .clock       (clock),
    .reset       (reset),
    .start       (seq_start),
    .kind        (seq_kind),
    .num_batches (seq_num),
    .fetch_ack   (bus.fetch_ack),
    .fetch_req   (bus.fetch_req),
    .fetch_kind  (bus.fetch_kind),
    .fetch_batch (bus.fetch_batch),
    .load        (seq_load),
    .last_gap    (seq_last)
  );

  assign bus.cfg_ready             = (state_q == ST_IDLE);
  assign bus.irb_start_block       = (state_q == ST_START);
  assign bus.irb_load_expand_data  = seq_load && (state_q == ST_EXPAND);
  assign bus.irb_load_project_data = seq_load && (state_q == ST_PROJECT);
  assign bus.irb_dw_window_valid   = (state_q == ST_DW);
  assign bus.irb_use_residual      = use_res_q;
  assign bus.done                  = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign bus.error                 = error_q;
  assign bus.error_code            = code_q;
endmodule

// File: tb/tb_irb_phase_scheduler.sv
// tb/tb_irb_phase_scheduler.sv - scoreboard bench for irb_phase_scheduler
module tb_irb_phase_scheduler;
  localparam int NM = 16;
  localparam int DWC = 9;
  localparam int TMO = 1024;

  localparam int EV_START = 0, EV_FETCH = 1, EV_LOAD_E = 2, EV_LOAD_P = 3, EV_DW = 4, EV_DONE = 5;

  typedef struct {
    int kind;
    int a;
    int b;
    int lat;
    bit refsel;
  } ev_t;

  logic clock;
  logic reset;
  irb_phase_scheduler_if #(.BATCH_W(7)) bus();

  irb_phase_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  acc_cyc = 0;
  int  ack_delay = 0, busy_delay = 1, ov_delay = 2, pb_cur = 1;
  bit  stray_ack = 0;
  bit  abort = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int act, int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic ev_t mk(int k, int a, int b, int lat, bit refsel);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.lat = lat; e.refsel = refsel;
    return e;
  endfunction

  // Reference: expected event stream of one run, from the channel counts alone
  task automatic push_run(int in_ch, int ex_ch, int out_ch, bit busy_never, int ov_k);
    int eb, pb;
    eb = (in_ch + NM - 1) / NM;
    pb = (ex_ch + NM - 1) / NM;
    if (in_ch == 0 || ex_ch == 0 || out_ch == 0) begin
      exp_q.push_back(mk(EV_DONE, 1, 1, 2, 0));
      return;
    end
    exp_q.push_back(mk(EV_START, 0, 0, 2, 0));
    if (busy_never) begin
      exp_q.push_back(mk(EV_DONE, 1, 2, 2 + 1 + TMO, 0));
      return;
    end
    for (int b = 0; b < eb; b++) begin
      exp_q.push_back(mk(EV_FETCH, 0, b, -1, 0));
      exp_q.push_back(mk(EV_LOAD_E, 0, 0, -1, 0));
    end
    exp_q.push_back(mk(EV_DW, pb * DWC, 0, 2, 0));
    for (int b = 0; b < pb; b++) begin
      exp_q.push_back(mk(EV_FETCH, 1, b, -1, 0));
      exp_q.push_back(mk(EV_LOAD_P, 0, 0, -1, 0));
    end
    exp_q.push_back(mk(EV_DONE, 0, 0, 1 + ((ov_k > 2) ? ov_k : 2), 1));
  endtask

  task automatic observe(int k, int a, int b, int rel0, int rel1);
    ev_t e;
    check($sformatf("ev%0d_expected", k), int'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("ev_kind", k, e.kind);
    if (k != e.kind) return;
    check($sformatf("ev%0d_a", k), a, e.a);
    check($sformatf("ev%0d_b", k), b, e.b);
    if (e.lat >= 0) check($sformatf("ev%0d_latency", k), e.refsel ? rel1 : rel0, e.lat);
  endtask

  // Monitor: turns DUT outputs into events and checks them against the queue
  initial begin : monitor
    int   dw_len = 0, dw_start = 0, last_le = 0, last_lp = 0;
    logic p_req = 0, p_ack = 0, p_load = 0, p_kind = 0;
    logic [6:0] p_batch = 0;
    forever begin
      @(negedge clock);
      if (reset || abort) begin
        dw_len = 0; p_req = 0; p_ack = 0; p_load = 0;
        continue;
      end
      if (p_req && !p_ack) begin
        check("fetch_req_held", int'(bus.fetch_req), 1);
        check("fetch_batch_stable", int'(bus.fetch_batch), int'(p_batch));
        check("fetch_kind_stable", int'(bus.fetch_kind), int'(p_kind));
      end
      if (bus.irb_load_expand_data || bus.irb_load_project_data)
        check("load_not_adjacent", int'(p_load), 0);
      if (bus.irb_dw_window_valid) begin
        if (dw_len == 0) dw_start = cyc;
        dw_len++;
      end else if (dw_len != 0) begin
        observe(EV_DW, dw_len, 0, dw_start - last_le, 0);
        dw_len = 0;
      end
      if (bus.irb_start_block) observe(EV_START, 0, 0, cyc - acc_cyc, 0);
      if (bus.fetch_req && bus.fetch_ack)
        observe(EV_FETCH, int'(bus.fetch_kind), int'(bus.fetch_batch), 0, 0);
      if (bus.irb_load_expand_data) begin
        observe(EV_LOAD_E, 0, 0, 0, 0);
        last_le = cyc;
      end
      if (bus.irb_load_project_data) begin
        observe(EV_LOAD_P, 0, 0, 0, 0);
        last_lp = cyc;
      end
      if (bus.done)
        observe(EV_DONE, int'(bus.error), int'(bus.error_code), cyc - acc_cyc, cyc - last_lp);
      p_req   = bus.fetch_req;
      p_ack   = bus.fetch_ack;
      p_kind  = bus.fetch_kind;
      p_batch = bus.fetch_batch;
      p_load  = bus.irb_load_expand_data || bus.irb_load_project_data;
    end
  end

  // Block/buffer model: acks fetches, raises busy, and produces output_valid
  initial begin : responder
    int req_cnt = 0, busy_t = 0, ov_t = 0, lp_seen = 0;
    bit busy_on = 0;
    bus.fetch_ack = 0;
    bus.irb_busy = 0;
    bus.irb_output_valid = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset || abort) begin
        req_cnt = 0; busy_t = 0; ov_t = 0; lp_seen = 0; busy_on = 0;
        bus.fetch_ack = 0; bus.irb_busy = 0; bus.irb_output_valid = 0;
        continue;
      end
      if (bus.fetch_req) begin
        bus.fetch_ack = (req_cnt == ack_delay);
        req_cnt++;
      end else begin
        req_cnt = 0;
        bus.fetch_ack = stray_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (busy_t > 0) begin
        busy_t--;
        if (busy_t == 0) busy_on = 1;
      end
      if (bus.irb_start_block && busy_delay > 0) busy_t = busy_delay;
      bus.irb_busy = busy_on;
      bus.irb_output_valid = 0;
      if (ov_t > 0) begin
        ov_t--;
        if (ov_t == 0) bus.irb_output_valid = 1;
      end
      if (bus.irb_load_project_data) begin
        lp_seen++;
        if (lp_seen == pb_cur) ov_t = ov_delay;
      end
      if (bus.done) begin
        busy_on = 0; lp_seen = 0; bus.irb_busy = 0;
      end
    end
  end

  task automatic offer_cfg(int in_ch, int ex_ch, int out_ch, bit res, output bit ok);
    ok = 0;
    @(posedge clock);
    #1;
    bus.cfg_input_channels  = 10'(in_ch);
    bus.cfg_expand_channels = 10'(ex_ch);
    bus.cfg_output_channels = 10'(out_ch);
    bus.cfg_use_residual    = res;
    bus.cfg_valid           = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.cfg_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    check("cfg_accepted", int'(ok), 1);
    @(posedge clock);
    #1;
    bus.cfg_valid = 0;
    @(negedge clock);
    check("cfg_ready_low_after_accept", int'(bus.cfg_ready), 0);
    check("error_cleared_on_accept", int'(bus.error), 0);
    check("use_residual_latched", int'(bus.irb_use_residual), int'(res));
  endtask

  task automatic run_cfg(int in_ch, int ex_ch, int out_ch, bit res, int ack_d, int busy_d, int ov_k);
    bit ok, seen;
    int err_exp, code_exp;
    ack_delay  = ack_d;
    busy_delay = busy_d;
    ov_delay   = ov_k;
    pb_cur     = (ex_ch + NM - 1) / NM;
    push_run(in_ch, ex_ch, out_ch, busy_d == 0, ov_k);
    err_exp  = (in_ch == 0 || ex_ch == 0 || out_ch == 0 || busy_d == 0) ? 1 : 0;
    code_exp = (in_ch == 0 || ex_ch == 0 || out_ch == 0) ? 1 : (busy_d == 0 ? 2 : 0);
    offer_cfg(in_ch, ex_ch, out_ch, res, ok);
    seen = 0;
    for (int i = 0; i < 3000 && ok; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    check("done_seen", int'(seen), 1);
    @(negedge clock);
    check("done_single_pulse", int'(bus.done), 0);
    check("error_sticky", int'(bus.error), err_exp);
    check("error_code_sticky", int'(bus.error_code), code_exp);
    check("cfg_ready_idle", int'(bus.cfg_ready), 1);
    check("events_consumed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_abort();
    bit ok, seen;
    ack_delay = 0; busy_delay = 1; ov_delay = 2; pb_cur = 2;
    exp_q.push_back(mk(EV_START, 0, 0, 2, 0));
    exp_q.push_back(mk(EV_FETCH, 0, 0, -1, 0));
    exp_q.push_back(mk(EV_LOAD_E, 0, 0, -1, 0));
    offer_cfg(16, 32, 16, 1, ok);
    seen = 0;
    for (int i = 0; i < 200 && ok; i++) begin
      if (bus.irb_dw_window_valid) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    check("dw_reached", int'(seen), 1);
    abort = 1;
    reset = 1;
    @(negedge clock);
    check("abort_start_block", int'(bus.irb_start_block), 0);
    check("abort_load_e", int'(bus.irb_load_expand_data), 0);
    check("abort_load_p", int'(bus.irb_load_project_data), 0);
    check("abort_dw_valid", int'(bus.irb_dw_window_valid), 0);
    check("abort_fetch_req", int'(bus.fetch_req), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_use_residual", int'(bus.irb_use_residual), 0);
    check("abort_cfg_ready", int'(bus.cfg_ready), 1);
    check("abort_events_consumed", exp_q.size(), 0);
    exp_q.delete();
    reset = 0;
    @(negedge clock);
    abort = 0;
  endtask

  initial begin : driver
    int ic, ec, oc;
    bus.cfg_valid = 0;
    bus.cfg_input_channels = 0;
    bus.cfg_expand_channels = 0;
    bus.cfg_output_channels = 0;
    bus.cfg_use_residual = 0;
    reset = 1;
    repeat (3) @(negedge clock);
    check("rst_cfg_ready", int'(bus.cfg_ready), 1);
    check("rst_fetch_req", int'(bus.fetch_req), 0);
    check("rst_fetch_batch", int'(bus.fetch_batch), 0);
    check("rst_start_block", int'(bus.irb_start_block), 0);
    check("rst_dw_valid", int'(bus.irb_dw_window_valid), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_error_code", int'(bus.error_code), 0);
    reset = 0;
    @(negedge clock);

    run_cfg(16, 32, 16, 0, 0, 1, 3);
    run_cfg(8, 16, 8, 1, 0, 2, 2);
    run_cfg(33, 64, 16, 0, 3, 1, 4);
    run_cfg(16, 0, 16, 0, 0, 1, 2);
    run_cfg(16, 16, 0, 1, 0, 1, 2);
    run_cfg(16, 16, 16, 0, 0, 0, 2);
    run_cfg(16, 16, 16, 1, 1, 3, 2);
    run_abort();
    run_cfg(16, 32, 16, 0, 0, 1, 1);
    run_cfg(1023, 1, 5, 1, 0, 1, 1);
    stray_ack = 1;
    run_cfg(17, 1, 3, 0, 2, 2, 3);
    for (int i = 0; i < 10; i++) begin
      ic = $urandom_range(1, 80);
      ec = $urandom_range(1, 80);
      oc = $urandom_range(1, 64);
      case ($urandom_range(0, 9))
        0: ic = 0;
        1: ec = 0;
        default: ;
      endcase
      stray_ack = 1'($urandom_range(0, 1));
      run_cfg(ic, ec, oc, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(1, 4), $urandom_range(1, 4));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
